dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port round-robin arbiter and access sequencer in front of DataMemory.
//  Port 0 (CPU load/store) and port 1 (DMA/debug) share the single-ported data memory.
//  The arbiter grants one request, drives MR/MW/Address/WriteData for exactly one cycle,
//  then returns an ack pulse. On reads it also returns the registered memory data.
//  It sits between the requesters and DataMemory. mem_* outputs connect 1:1 to DataMemory inputs.
// PARAMETERS
//  DATA_W  32   data width, equals DataMemory word width
//  ADDR_W  32   request/memory address width (word index)
//  DEPTH   256  number of implemented words; addresses >= DEPTH are rejected
// PORTS
//  clk          in   1       system clock; memory reads on posedge, writes on negedge
//  rst_n        in   1       asynchronous active-low reset
//  req0/req1    in   1       access request, held with command stable until ack
//  we0/we1      in   1       1 = write, 0 = read
//  addr0/addr1  in   ADDR_W  word address
//  wdata0/1     in   DATA_W  write data
//  ack0/ack1    out  1       one-cycle completion pulse
//  rdata0/1     out  DATA_W  read data, valid only while ackN=1, else 0
//  err0/err1    out  1       with ackN: address out of range, no memory access done
//  busy         out  1       1 whenever FSM != IDLE
//  mem_mr       out  1       -> DataMemory MR
//  mem_mw       out  1       -> DataMemory MW
//  mem_addr     out  ADDR_W  -> DataMemory Address
//  mem_wdata    out  DATA_W  -> DataMemory WriteData
//  mem_rdata    in   DATA_W  <- DataMemory ReadData
// BEHAVIOUR
//  FSM states: IDLE, ACCESS, RESP. Registered state, outputs decoded from registers only.
//  IDLE: requests are sampled at the posedge only in this state.
//   - If any reqN=1, latch winner id, we, addr and wdata.
//   - addr < DEPTH -> ACCESS. addr >= DEPTH -> RESP with err flag set.
//  ACCESS (exactly 1 cycle):
//   - mem_addr/mem_wdata = latched values.
//   - mem_mr = ~we, mem_mw = we.
//   - Memory write lands at the negedge inside this cycle.
//   - Read data is captured by DataMemory at the posedge that ends ACCESS. Next state RESP.
//  RESP (exactly 1 cycle):
//   - ackN=1 for the winner.
//   - Read: rdataN = mem_rdata. Write or err: rdataN = 0.
//   - errN = latched err flag. mem_mr = mem_mw = 0. Next state IDLE.
//  Latency: req sampled at edge E -> ack in cycle E+2 (in range) or E+1 (err).
//   Max throughput is one access per 3 cycles.
//  Handshake:
//   - Requester drops reqN at the posedge ending the ack cycle, or keeps it high to issue a new request.
//   - reqN high in IDLE always means a new request.
//   - Changing we/addr/wdata while req is pending and before grant is allowed; values are taken at the grant edge.
//  Arbitration: round-robin via last_grant register, reset value 1, so port 0 wins the first tie.
//   - On simultaneous req0 and req1, grant the port != last_grant.
//   - A single requester is always granted. last_grant updates on every grant, including err grants.
//   - The loser's req stays pending and is granted at the next IDLE sample. No starvation.
//  mem_mr and mem_mw are never both 1 and never 1 outside ACCESS.
//   mem_addr/mem_wdata hold their last value outside ACCESS.
//  Reset (async, any state): FSM -> IDLE, last_grant -> 1, every output -> 0.
//   - Reset asserted during ACCESS drops mem_mw immediately. A pending write is aborted if reset precedes the negedge.
//   - An in-flight access never gets an ack after reset. Requesters must reissue.
//  Address compare is unsigned, full ADDR_W bits. No wrap-around.
// TESTING
//  1 Reset: rst_n=0 mid-ACCESS write -> mem_mw falls same time step, all outputs 0, busy=0; mem[addr] unchanged if before negedge.
//  2 Write then read: port0 write addr 5 data 0xDEADBEEF, ack0 2 cycles later; port0 read addr 5 -> ack0 with rdata0=0xDEADBEEF, rdata1=0.
//  3 Tie: req0=req1=1 from reset -> port0 granted first, then port1; 4 back-to-back ties alternate 0,1,0,1.
//  4 Out of range: port1 read addr 256 -> ack1 with err1=1, rdata1=0 one cycle after sample, mem_mr never asserted.
//  5 Held req: port0 keeps req0 high over 3 reads, port1 idle -> an access every 3 cycles, each with correct data.
//  6 Assertions: never (mem_mr & mem_mw), ack0 & ack1 never together, ack only in RESP.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter sequencing one-cycle accesses to a single-ported data memory
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic              mem_mr,
  output logic              mem_mw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic win, last_grant, we_q, err_q;
  logic any_req, gnt, g_we, g_err;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata, rd;
  always_comb begin
    any_req  = req0 | req1;
    gnt      = (req0 & req1) ? ~last_grant : req1;
    g_we     = gnt ? we1 : we0;
    g_addr   = gnt ? addr1 : addr0;
    g_wdata  = gnt ? wdata1 : wdata0;
    g_err    = g_addr >= ADDR_W'(DEPTH);
    state_nx = state == IDLE   ? (any_req ? (g_err ? RESP : ACCESS) : IDLE) :
               state == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win        <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        win        <= gnt;
        last_grant <= gnt;
        we_q       <= g_we;
        err_q      <= g_err;
        // rejected addresses never reach the memory bus
        if (!g_err) begin
          mem_addr  <= g_addr;
          mem_wdata <= g_wdata;
        end
      end
    end
  end
  always_comb begin
    busy   = state != IDLE;
    mem_mr = (state == ACCESS) & ~we_q;
    mem_mw = (state == ACCESS) & we_q;
    ack0   = (state == RESP) & ~win;
    ack1   = (state == RESP) & win;
    err0   = ack0 & err_q;
    err1   = ack1 & err_q;
    rd     = (state == RESP && !we_q && !err_q) ? mem_rdata : '0;
    rdata0 = win ? '0 : rd;
    rdata1 = win ? rd : '0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a queued scoreboard checked by an independent ack monitor
module tb_dmem_arbiter;
  logic clk = 0, rst_n = 0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic ack0, ack1, err0, err1, busy, mem_mr, mem_mw;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata = 0;
  logic [31:0] mem [0:255];
  int checks = 0, errors = 0, cyc = 0, acks = 0, mr_cnt = 0;

  typedef struct {int port; logic err; logic [31:0] data; int iss; int lat;} exp_t;
  exp_t q[$];
  exp_t e;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .busy(busy), .mem_mr(mem_mr), .mem_mw(mem_mw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
  always @(posedge clk) if (mem_mr) mem_rdata <= mem[mem_addr[7:0]];
  always @(negedge clk) if (mem_mw) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mem_mr) mr_cnt++;
    chk("mr_mw_exclusive", {63'd0, mem_mr & mem_mw}, 0);
    if (ack0 | ack1) begin
      acks++;
      chk("ack_exclusive", {63'd0, ack0 & ack1}, 0);
      chk("ack_in_resp", {62'd0, busy, mem_mr | mem_mw}, 64'h2);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
      end else begin
        e = q.pop_front();
        chk("ack_port", {63'd0, ack1}, e.port);
        chk("rdata", e.port ? rdata1 : rdata0, e.data);
        chk("rdata_other", e.port ? rdata0 : rdata1, 0);
        chk("err", {63'd0, e.port ? err1 : err0}, {63'd0, e.err});
        chk("err_other", {63'd0, e.port ? err0 : err1}, 0);
        if (e.lat >= 0) chk("latency", cyc - e.iss, e.lat);
      end
    end
  end

  task automatic txn(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input bit exp_err, input int lat, input bit hold,
                     output int ack_at);
    exp_t x;
    x = '{p, exp_err, exp_d, cyc, lat};
    q.push_back(x);
    if (p == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1; end
    else begin we1 = we; addr1 = a; wdata1 = d; req1 = 1; end
    ack_at = -1;
    for (int i = 0; i < 20 && ack_at < 0; i++) begin
      @(negedge clk); #1;
      if (p == 0 ? ack0 : ack1) ack_at = cyc;
    end
    if (ack_at < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack on port %0d expected ack within 20 cycles", p);
    end
    @(posedge clk); #1;
    if (!hold) begin if (p == 0) req0 = 0; else req1 = 0; end
  endtask

  initial begin
    int t, a1, a2, a3, base, mr0;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {ack0, ack1, err0, err1, busy, mem_mr, mem_mw}, 0);
    chk("rst_buses", {rdata0 | rdata1, mem_addr | mem_wdata}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    // four back-to-back ties: port 0 wins first, then alternation
    we0 = 1; addr0 = 10; wdata0 = 32'hA0A0A0A0; we1 = 1; addr1 = 11; wdata1 = 32'hB1B1B1B1;
    q.push_back('{0, 1'b0, 32'h0, cyc, 2});
    q.push_back('{1, 1'b0, 32'h0, cyc, -1});
    q.push_back('{0, 1'b0, 32'h0, cyc, -1});
    q.push_back('{1, 1'b0, 32'h0, cyc, -1});
    req0 = 1; req1 = 1;
    base = acks;
    for (int i = 0; i < 60 && acks < base + 4; i++) begin @(negedge clk); #1; end
    chk("tie_ack_count", acks - base, 4);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    @(posedge clk); #1;
    txn(0, 1, 5, 32'hDEADBEEF, 0, 0, 2, 0, t);
    txn(0, 0, 5, 0, 32'hDEADBEEF, 0, 2, 0, t);
    txn(1, 0, 10, 0, 32'hA0A0A0A0, 0, 2, 0, t);
    txn(0, 0, 11, 0, 32'hB1B1B1B1, 0, 2, 0, t);
    mr0 = mr_cnt;
    txn(1, 0, 256, 0, 0, 1, 1, 0, t);
    txn(0, 1, 32'hFFFFFFFF, 32'h12345678, 0, 1, 1, 0, t);
    chk("oor_no_mem_read", mr_cnt - mr0, 0);
    chk("oor_no_write_wrap", mem[255], 32'h10FF);
    txn(0, 0, 255, 0, 32'h10FF, 0, 2, 0, t);
    txn(0, 0, 20, 0, 32'h1014, 0, 2, 1, a1);
    txn(0, 0, 21, 0, 32'h1015, 0, 2, 1, a2);
    txn(0, 0, 22, 0, 32'h1016, 0, 2, 0, a3);
    chk("held_spacing_1", a2 - a1, 3);
    chk("held_spacing_2", a3 - a2, 3);
    we0 = 1; addr0 = 7; wdata0 = 32'h77777777; req0 = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = mem_mw;
    end
    chk("mw_reached", {63'd0, seen}, 1);
    rst_n = 0;
    #1;
    req0 = 0;
    chk("rst_mid_outputs", {ack0, ack1, err0, err1, busy, mem_mr, mem_mw}, 0);
    chk("rst_mid_buses", {mem_addr, mem_wdata}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write_aborted", mem[7], 32'h1007);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    txn(0, 0, 7, 0, 32'h1007, 0, 2, 0, t);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
